dcache_line_xfer: RTL

- Memory-side responder for the data cache's nibble-serial line-fill/write-back interface.
- On a cache `push`, it drives `rstrobe_d` and streams the cache's `dwrite` nibbles to an external quad-SPI memory as a write.
- On a `pull`, it issues a quad-SPI read and returns nibbles on `dread` with `wstrobe_d`.
- It sits between `dcache` and the external memory pins and owns the command, address, dummy, data and CS-recovery sequencing.

---
 rtl/dcache_xfer_pkg.sv | 37 +++
 rtl/dcache_line_xfer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_xfer_pkg.sv
// Shared types and constants for the data-cache line transfer engine.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the sequencer state encoding, the fixed phase lengths of a
// quad-SPI line transfer and the default command bytes.
package dcache_xfer_pkg;

    // Transfer sequencer states, in the order a transfer walks through them.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_RECOV = 3'd5
    } state_e;

    // Phase lengths in nibble (clock) cycles.
    localparam int LINE_BYTES = 4;
    localparam int CMD_NIB    = 2;
    localparam int ADDR_NIB   = 6;
    localparam int DATA_NIB   = 2 * LINE_BYTES;

    // Memory-side address is always 24 bits on the wire.
    localparam int MEM_ADDR_W = 24;

    // Default quad-SPI command bytes.
    localparam logic [7:0] CMD_READ_DEF  = 8'hEB;
    localparam logic [7:0] CMD_WRITE_DEF = 8'h38;

    // Phase counter reload value for a phase of 'len' cycles.
    function automatic logic [3:0] phase_last(input int len);
        return 4'(len - 1);
    endfunction

endpackage

// File: rtl/dcache_line_xfer.sv
// Nibble-serial line-fill / write-back responder between dcache and a quad-SPI memory.
// Latency: push done at T+17, pull done at T+24 (DUMMY_CYCLES=6) after the accept cycle T.
// Backpressure: none inside a transfer; start is ignored while busy.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start, push, pull, tag     cache miss-service request, latched on accept
//   dwrite / rstrobe_d         write-back nibble from the cache / consume strobe
//   dread  / wstrobe_d         fill nibble to the cache / valid strobe
//   busy, done                 transfer (incl. CS recovery) in progress / completion pulse
//   mem_cs_n, mem_sck_en       memory chip select (active low), clock gate enable
//   mem_oe, mem_out, mem_in    memory data pins: drive enable, outgoing and incoming nibble
module dcache_line_xfer
    import dcache_xfer_pkg::*;
#(
    parameter int         PA           = 22,
    parameter int         LINE_LENGTH  = 4,
    parameter logic [7:0] CMD_READ     = CMD_READ_DEF,
    parameter logic [7:0] CMD_WRITE    = CMD_WRITE_DEF,
    parameter int         DUMMY_CYCLES = 6,
    parameter int         CS_HIGH      = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          push,
    input  logic          pull,
    input  logic [PA-3:0] tag,
    input  logic [3:0]    dwrite,
    output logic          rstrobe_d,
    output logic          wstrobe_d,
    output logic [3:0]    dread,
    output logic          busy,
    output logic          done,
    output logic          mem_cs_n,
    output logic          mem_sck_en,
    output logic          mem_oe,
    output logic [3:0]    mem_out,
    input  logic [3:0]    mem_in
);

    localparam logic [3:0] CMD_LAST   = phase_last(CMD_NIB);
    localparam logic [3:0] ADDR_LAST  = phase_last(ADDR_NIB);
    localparam logic [3:0] DUMMY_LAST = phase_last(DUMMY_CYCLES);
    localparam logic [3:0] DATA_LAST  = phase_last(2 * LINE_LENGTH);
    localparam logic [3:0] RECOV_LAST = phase_last(CS_HIGH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e        state_q,   state_d;
    logic [3:0]    cnt_q,     cnt_d;       // shared phase counter, counts down to 0
    logic          op_push_q, op_push_d;   // 1: write-back, 0: line fill
    logic [PA-3:0] tag_q,     tag_d;
    logic [3:0]    dread_q,   dread_d;
    logic          wstrobe_q, wstrobe_d_n;
    logic          done_q,    done_d;

    logic [MEM_ADDR_W-1:0] addr24;
    logic [7:0]            cmd_byte;
    logic [3:0]            addr_nib;
    logic                  phase_end;

    // Byte address of the line, zero-extended to the 24-bit wire address.
    assign addr24    = MEM_ADDR_W'({tag_q, 2'b00});
    assign cmd_byte  = op_push_q ? CMD_WRITE : CMD_READ;
    assign phase_end = (cnt_q == 4'd0);

    // Address nibbles go out MSB first while the counter runs 5 -> 0.
    always_comb begin
        addr_nib = addr24[3:0];
        case (cnt_q)
            4'd5:    addr_nib = addr24[23:20];
            4'd4:    addr_nib = addr24[19:16];
            4'd3:    addr_nib = addr24[15:12];
            4'd2:    addr_nib = addr24[11:8];
            4'd1:    addr_nib = addr24[7:4];
            default: addr_nib = addr24[3:0];
        endcase
    end

    // ------------------------------------------------------------------
    // Next state and pin outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_push_d  = op_push_q;
        tag_d      = tag_q;
        mem_cs_n   = 1'b1;
        mem_sck_en = 1'b0;
        mem_oe     = 1'b0;
        mem_out    = 4'h0;
        rstrobe_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && (push || pull)) begin
                    // Write-back has priority so a dirty victim is never lost.
                    op_push_d = push;
                    tag_d     = tag;
                    state_d   = ST_CMD;
                    cnt_d     = CMD_LAST;
                end
            end

            ST_CMD: begin
                mem_cs_n   = 1'b0;
                mem_sck_en = 1'b1;
                mem_oe     = 1'b1;
                mem_out    = (cnt_q == 4'd1) ? cmd_byte[7:4] : cmd_byte[3:0];
                if (phase_end) begin
                    state_d = ST_ADDR;
                    cnt_d   = ADDR_LAST;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_ADDR: begin
                mem_cs_n   = 1'b0;
                mem_sck_en = 1'b1;
                mem_oe     = 1'b1;
                mem_out    = addr_nib;
                if (phase_end) begin
                    if (op_push_q) begin
                        state_d = ST_DATA;
                        cnt_d   = DATA_LAST;
                    end else begin
                        state_d = ST_DUMMY;
                        cnt_d   = DUMMY_LAST;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_DUMMY: begin
                // Bus turnaround: release the data pins before the memory drives.
                mem_cs_n   = 1'b0;
                mem_sck_en = 1'b1;
                if (phase_end) begin
                    state_d = ST_DATA;
                    cnt_d   = DATA_LAST;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_DATA: begin
                mem_cs_n   = 1'b0;
                mem_sck_en = 1'b1;
                if (op_push_q) begin
                    // The cache presents the nibble at its current offset and
                    // advances on this strobe, so dwrite passes straight through.
                    mem_oe    = 1'b1;
                    mem_out   = dwrite;
                    rstrobe_d = 1'b1;
                end
                if (phase_end) begin
                    state_d = ST_RECOV;
                    cnt_d   = RECOV_LAST;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_RECOV: begin
                if (phase_end) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fill data path and completion pulse
    // ------------------------------------------------------------------
    always_comb begin
        wstrobe_d_n = (state_q == ST_DATA) && !op_push_q;
        dread_d     = wstrobe_d_n ? mem_in : dread_q;
        // Write-back completes after its last DATA cycle. A fill completes one
        // cycle after its last registered strobe, which lands in the first
        // RECOV cycle; wstrobe_q is only ever set by fills.
        done_d      = ((state_q == ST_DATA) && op_push_q && phase_end) ||
                      ((state_q == ST_RECOV) && wstrobe_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            op_push_q <= 1'b0;
            tag_q     <= '0;
            dread_q   <= 4'h0;
            wstrobe_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_push_q <= op_push_d;
            tag_q     <= tag_d;
            dread_q   <= dread_d;
            wstrobe_q <= wstrobe_d_n;
            done_q    <= done_d;
        end
    end

    assign dread     = dread_q;
    assign wstrobe_d = wstrobe_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
